// File: rtl/gpu_stencil_pkg.sv
// Shared widths, FSM states and masked-write helper for the stencil pixel controller.
package gpu_stencil_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int SADR_W  = 15;
    localparam int SWORD_W = 16;
    localparam int BIT_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        RDWAIT,
        OUT
    } state_t;

    typedef struct packed {
        logic [SWORD_W-1:0] mask;
        logic [SWORD_W-1:0] value;
    } wr_bits_t;

    function automatic wr_bits_t wr_bits(input logic [BIT_W-1:0] b, input logic val);
        wr_bits_t r;
        r.mask  = SWORD_W'(1) << b;
        r.value = {SWORD_W{val}} & r.mask;
        return r;
    endfunction

endpackage

// File: rtl/gpu_stencil_addr_gen.sv
// Combinational pixel-to-stencil decode: word address, bit index and single-bit mask.
// Shared by the read and write request paths so both always target the same word.
module gpu_stencil_addr_gen
    import gpu_stencil_pkg::*;
(
    input  logic [X_W-1:0]     i_x,
    input  logic [Y_W-1:0]     i_y,
    output logic [SADR_W-1:0]  o_addr,
    output logic [BIT_W-1:0]   o_bit,
    output logic [SWORD_W-1:0] o_mask
);

    wr_bits_t w_bits;

    assign o_addr = {i_y, i_x[X_W-1:BIT_W]};
    assign o_bit  = i_x[BIT_W-1:0];
    assign w_bits = wr_bits(i_x[BIT_W-1:0], 1'b1);
    assign o_mask = w_bits.mask;

endmodule

// File: rtl/gpu_stencil_pixel_ctrl.sv
// Per-pixel stencil test/update sequencer in front of the stencil cache.
// Optional sticky error flag enabled by GPU_STENCIL_ERR_LATCH_EN.
module gpu_stencil_pixel_ctrl
    import gpu_stencil_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [X_W-1:0]     in_x_i,
    input  logic [Y_W-1:0]     in_y_i,
    input  logic               in_check_i,
    input  logic               in_set_i,
    input  logic               in_set_val_i,
    output logic               stencil_rd_req_o,
    output logic [SADR_W-1:0]  stencil_rd_addr_o,
    input  logic [SWORD_W-1:0] stencil_rd_value_i,
    output logic               stencil_wr_req_o,
    output logic [SADR_W-1:0]  stencil_wr_addr_o,
    output logic [SWORD_W-1:0] stencil_wr_mask_o,
    output logic [SWORD_W-1:0] stencil_wr_value_o,
    input  logic               stencil_error_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               out_pass_o,
    output logic [X_W-1:0]     out_x_o,
    output logic [Y_W-1:0]     out_y_o,
    output logic               err_o,
    input  logic               err_clr_i
);

    state_t             r_state, w_next;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic               r_set, r_set_val, r_pass;
    logic               w_acc, w_rd, w_wr, w_set_val, w_pass_d;
    logic [X_W-1:0]     w_x;
    logic [Y_W-1:0]     w_y;
    logic [SADR_W-1:0]  w_addr;
    logic [BIT_W-1:0]   w_bit;
    logic [SWORD_W-1:0] w_mask;
    wr_bits_t           w_bits;

    assign in_ready_o = (r_state == IDLE) && !rst_i;
    assign w_acc      = in_valid_i && in_ready_o;

    // In IDLE the decode follows the live request; afterwards the latched one.
    assign w_x = (r_state == IDLE) ? in_x_i : r_x;
    assign w_y = (r_state == IDLE) ? in_y_i : r_y;

    gpu_stencil_addr_gen u_addr_gen (
        .i_x    (w_x),
        .i_y    (w_y),
        .o_addr (w_addr),
        .o_bit  (w_bit),
        .o_mask (w_mask)
    );

    always_comb begin
        w_next    = r_state;
        w_rd      = 1'b0;
        w_wr      = 1'b0;
        w_set_val = r_set_val;
        w_pass_d  = r_pass;
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    if (in_check_i) begin
                        w_rd   = 1'b1;
                        w_next = RDWAIT;
                    end else begin
                        w_wr      = in_set_i;
                        w_set_val = in_set_val_i;
                        w_pass_d  = 1'b1;
                        w_next    = OUT;
                    end
                end
            end
            RDWAIT: begin
                w_pass_d = ~stencil_rd_value_i[w_bit];
                w_wr     = ~stencil_rd_value_i[w_bit] & r_set;
                w_next   = OUT;
            end
            OUT: begin
                if (out_ready_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_set     <= 1'b0;
            r_set_val <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pass  <= w_pass_d;
            if (w_acc) begin
                r_x       <= in_x_i;
                r_y       <= in_y_i;
                r_set     <= in_set_i;
                r_set_val <= in_set_val_i;
            end
        end
    end

    assign w_bits             = wr_bits(w_bit, w_set_val);
    assign stencil_rd_req_o   = w_rd;
    assign stencil_rd_addr_o  = w_addr;
    assign stencil_wr_req_o   = w_wr;
    assign stencil_wr_addr_o  = w_addr;
    assign stencil_wr_mask_o  = w_mask;
    assign stencil_wr_value_o = w_bits.value;
    assign out_valid_o        = (r_state == OUT);
    assign out_pass_o         = r_pass;
    assign out_x_o            = r_x;
    assign out_y_o            = r_y;

`ifdef GPU_STENCIL_ERR_LATCH_EN
    logic r_wr_q, r_err, w_illegal;

    assign w_illegal = (w_rd && w_wr) || (r_wr_q && (w_rd || w_wr));

    // Set has priority over clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_q <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_wr_q <= w_wr;
            if (w_illegal || stencil_error_i) r_err <= 1'b1;
            else if (err_clr_i)               r_err <= 1'b0;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_err;
    assign w_unused_err = stencil_error_i ^ err_clr_i;
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_stencil_pixel_ctrl.sv
// Scoreboard bench for gpu_stencil_pixel_ctrl against a per-pixel stencil bitmap model.
module tb_gpu_stencil_pixel_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0, in_ready_o;
    logic [9:0]  in_x_i = '0;
    logic [8:0]  in_y_i = '0;
    logic        in_check_i = 1'b0, in_set_i = 1'b0, in_set_val_i = 1'b0;
    logic        stencil_rd_req_o, stencil_wr_req_o;
    logic [14:0] stencil_rd_addr_o, stencil_wr_addr_o;
    logic [15:0] stencil_rd_value_i = '0;
    logic [15:0] stencil_wr_mask_o, stencil_wr_value_o;
    logic        stencil_error_i = 1'b0;
    logic        out_valid_o, out_ready_i = 1'b0, out_pass_o;
    logic [9:0]  out_x_o;
    logic [8:0]  out_y_o;
    logic        err_o, err_clr_i = 1'b0;

    gpu_stencil_pixel_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_x_i(in_x_i), .in_y_i(in_y_i),
        .in_check_i(in_check_i), .in_set_i(in_set_i), .in_set_val_i(in_set_val_i),
        .stencil_rd_req_o(stencil_rd_req_o), .stencil_rd_addr_o(stencil_rd_addr_o),
        .stencil_rd_value_i(stencil_rd_value_i),
        .stencil_wr_req_o(stencil_wr_req_o), .stencil_wr_addr_o(stencil_wr_addr_o),
        .stencil_wr_mask_o(stencil_wr_mask_o), .stencil_wr_value_o(stencil_wr_value_o),
        .stencil_error_i(stencil_error_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pass_o(out_pass_o), .out_x_o(out_x_o), .out_y_o(out_y_o),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { int pass; int x; int y; int cyc; int lat; } vexp_t;
    typedef struct { int addr; int mask; int value; int cyc; } rexp_t;
    vexp_t outq[$];
    rexp_t rdq[$];
    rexp_t wrq[$];

    bit          ref_bits [0:511][0:1023];
    logic [15:0] mem [0:32767];
    int          stall_cnt = 0;

`ifdef GPU_STENCIL_ERR_LATCH_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference: stencil bit per pixel, verdict and side effects from the rules directly.
    task automatic model(input int x, input int y, input bit chk, input bit set, input bit val, input int c);
        int  word;
        int  m;
        bit  pass;
        word = y * 64 + x / 16;
        m    = 1 << (x % 16);
        pass = !(chk && ref_bits[y][x]);
        if (chk) rdq.push_back('{word, 0, 0, c});
        if (pass && set) begin
            wrq.push_back('{word, m, val ? m : 0, chk ? c + 1 : c});
            ref_bits[y][x] = val;
        end
        outq.push_back('{int'(pass), x, y, c, chk ? 2 : 1});
    endtask

    task automatic send(input int x, input int y, input bit chk, input bit set, input bit val);
        int n;
        n = 0;
        in_x_i = 10'(x); in_y_i = 9'(y);
        in_check_i = chk; in_set_i = set; in_set_val_i = val;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        while (!in_ready_o) begin
            n++;
            if (n > 100) begin
                check("accept_timeout", 0, 1);
                in_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        model(x, y, chk, set, val, cyc);
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
    endtask

    // Stencil cache stand-in: read data valid in the cycle after the request.
    initial begin
        logic        p_rd, p_wr;
        logic [14:0] p_ra, p_wa;
        logic [15:0] p_m, p_v;
        for (int i = 0; i < 32768; i++) mem[i] = '0;
        forever begin
            @(negedge clk_i);
            p_rd = stencil_rd_req_o; p_ra = stencil_rd_addr_o;
            p_wr = stencil_wr_req_o; p_wa = stencil_wr_addr_o;
            p_m  = stencil_wr_mask_o; p_v = stencil_wr_value_o;
            @(posedge clk_i); #1;
            if (p_rd) stencil_rd_value_i = mem[p_ra];
            if (p_wr) mem[p_wa] = (mem[p_wa] & ~p_m) | (p_v & p_m);
        end
    end

    initial begin
        forever begin
            @(posedge clk_i); #1;
            if (stall_cnt > 0) begin
                out_ready_i = 1'b0;
                stall_cnt--;
            end else begin
                out_ready_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: request strobes, strobe protocol, verdict handshake and stall stability.
    initial begin
        bit   prev_wr;
        bit   timed;
        int   h_pass, h_x, h_y;
        rexp_t r;
        vexp_t v;
        prev_wr = 0; timed = 0; h_pass = 0; h_x = 0; h_y = 0;
        forever begin
            @(negedge clk_i); #1;
            if (rst_i) begin
                prev_wr = 0; timed = 0;
            end else begin
                if (stencil_rd_req_o) begin
                    if (rdq.size() == 0) check("unexpected_rd", 1, 0);
                    else begin
                        r = rdq.pop_front();
                        check("rd_addr", int'(stencil_rd_addr_o), r.addr);
                        check("rd_cycle", cyc, r.cyc);
                    end
                end
                if (stencil_wr_req_o) begin
                    if (wrq.size() == 0) check("unexpected_wr", 1, 0);
                    else begin
                        r = wrq.pop_front();
                        check("wr_addr", int'(stencil_wr_addr_o), r.addr);
                        check("wr_mask", int'(stencil_wr_mask_o), r.mask);
                        check("wr_value", int'(stencil_wr_value_o), r.value);
                        check("wr_cycle", cyc, r.cyc);
                    end
                end
                if (stencil_rd_req_o || stencil_wr_req_o) begin
                    check("rd_wr_overlap", int'(stencil_rd_req_o && stencil_wr_req_o), 0);
                    check("req_after_wr", int'(prev_wr), 0);
                end
                prev_wr = stencil_wr_req_o;
                if (out_valid_o) begin
                    check("ready_in_out", int'(in_ready_o), 0);
                    if (outq.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else if (!timed) begin
                        check("latency", cyc - outq[0].cyc, outq[0].lat);
                        timed = 1;
                    end else begin
                        check("stall_pass", int'(out_pass_o), h_pass);
                        check("stall_x", int'(out_x_o), h_x);
                        check("stall_y", int'(out_y_o), h_y);
                    end
                    h_pass = int'(out_pass_o); h_x = int'(out_x_o); h_y = int'(out_y_o);
                    if (out_ready_i && outq.size() != 0) begin
                        v = outq.pop_front();
                        check("out_pass", int'(out_pass_o), v.pass);
                        check("out_x", int'(out_x_o), v.x);
                        check("out_y", int'(out_y_o), v.y);
                        timed = 0;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        #2;
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_out_pass", int'(out_pass_o), 0);
        check("rst_out_x", int'(out_x_o), 0);
        check("rst_out_y", int'(out_y_o), 0);
        check("rst_rd_req", int'(stencil_rd_req_o), 0);
        check("rst_wr_req", int'(stencil_wr_req_o), 0);
        check("rst_err", int'(err_o), 0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready", int'(in_ready_o), 1);
        @(posedge clk_i); #1;

        send(37, 3, 1, 1, 1);
        send(37, 3, 1, 1, 1);
        send(1023, 511, 0, 1, 0);
        stall_cnt = 7;
        send(10, 1, 0, 0, 0);
        stall_cnt = 6;
        send(11, 1, 1, 1, 1);

        for (int t = 0; t < 300; t++) begin
            send($urandom_range(0, 47), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk_i); #1;
            end
        end

        n = 0;
        while (outq.size() != 0 && n < 500) begin
            @(posedge clk_i);
            n++;
        end
        repeat (3) @(posedge clk_i);
        #1;
        check("drain_out", outq.size(), 0);
        check("drain_rd", rdq.size(), 0);
        check("drain_wr", wrq.size(), 0);

        // Reset while the read result is pending.
        in_x_i = 10'd5; in_y_i = 9'd1; in_check_i = 1'b1; in_set_i = 1'b1; in_set_val_i = 1'b1;
        in_valid_i = 1'b1;
        @(negedge clk_i);
        check("pre_rst_ready", int'(in_ready_o), 1);
        rdq.push_back('{1 * 64 + 0, 0, 0, cyc});
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid_o), 0);
        check("midrst_rd", int'(stencil_rd_req_o), 0);
        check("midrst_wr", int'(stencil_wr_req_o), 0);
        check("midrst_in_ready", int'(in_ready_o), 0);
        check("midrst_pass", int'(out_pass_o), 0);
        check("midrst_x", int'(out_x_o), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("postrst_ready", int'(in_ready_o), 1);
        check("postrst_valid", int'(out_valid_o), 0);
        check("postrst_rdq", rdq.size(), 0);

        @(posedge clk_i); #1 stencil_error_i = 1'b1;
        @(posedge clk_i); #1 stencil_error_i = 1'b0;
        check("err_set", int'(err_o), ERR_EXP);
        repeat (3) @(posedge clk_i);
        #1 check("err_hold", int'(err_o), ERR_EXP);
        stencil_error_i = 1'b1; err_clr_i = 1'b1;
        @(posedge clk_i); #1;
        stencil_error_i = 1'b0;
        check("err_set_wins", int'(err_o), ERR_EXP);
        @(posedge clk_i); #1;
        err_clr_i = 1'b0;
        check("err_clr", int'(err_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
